// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, MODE bit positions and parameter
// legality checks for the parametrised SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } spi_state_t;

    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

    function automatic bit width_ok(input int w);
        return (w >= 2) && (w <= 32);
    endfunction

    function automatic bit div_ok(input int d);
        return d >= 2;
    endfunction

    function automatic bit cs_ok(input int n);
        return (n >= 1) && (n <= 8);
    endfunction

    function automatic bit params_ok(input int w, input int d, input int n);
        return width_ok(w) && div_ok(d) && cs_ok(n);
    endfunction

    function automatic int cs_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: counts SYS_CLK cycles 0..CLK_DIV-1 and flags the
// last one as the SCK half-period tick.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic SYS_CLK,
    input  logic RSTbar,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge SYS_CLK) begin
        if (!RSTbar) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master with per-transfer CPOL/CPHA.
// SCK is a registered output advanced by divider ticks on SYS_CLK.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 4,
    parameter int NUM_CS    = 1,
    parameter int LSB_FIRST = 0,
    localparam int CSW      = cs_sel_w(NUM_CS)
) (
    input  logic              SYS_CLK,
    input  logic              RSTbar,
    input  logic              START,
    input  logic [CSW-1:0]    CS_SEL,
    input  logic [1:0]        MODE,
    input  logic [DATA_W-1:0] DATA_MOSI,
    input  logic              MISO,
    output logic              SCK,
    output logic              MOSI,
    output logic [NUM_CS-1:0] CSbar,
    output logic              BUSY,
    output logic              FIN,
    output logic [DATA_W-1:0] DATA_MISO
);

    if (!params_ok(DATA_W, CLK_DIV, NUM_CS)) begin : g_bad_params
        $error("spi_master_param: illegal parameter set");
    end

    localparam int BCW = $clog2(DATA_W) + 1;
    localparam logic [BCW-1:0] BITS = BCW'(DATA_W);

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(
        input logic [DATA_W-1:0] w
    );
        return (LSB_FIRST != 0) ? {1'b0, w[DATA_W-1:1]}
                                : {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] rx_shift(
        input logic [DATA_W-1:0] w,
        input logic              b
    );
        return (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]}
                                : {w[DATA_W-2:0], b};
    endfunction

    // Out-of-range selects decode to no active line.
    function automatic logic [NUM_CS-1:0] cs_decode(
        input logic [CSW-1:0] sel
    );
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(sel) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    spi_state_t        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CSW-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [BCW-1:0]    cnt_q, cnt_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] csb_q, csb_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;
    logic [DATA_W-1:0] dm_q, dm_d;
    logic              clr, tick, lead, cpha;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .SYS_CLK (SYS_CLK),
        .RSTbar  (RSTbar),
        .clr     (clr),
        .en      (state_q != ST_IDLE),
        .tick    (tick)
    );

    assign cpha = mode_q[MODE_CPHA];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        csb_d   = csb_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        dm_d    = dm_q;
        clr     = 1'b0;
        lead    = (sck_q == mode_q[MODE_CPOL]);
        unique case (state_q)
            ST_IDLE: begin
                sck_d = mode_q[MODE_CPOL];
                if (START) begin
                    clr     = 1'b1;
                    mode_d  = MODE;
                    sel_d   = CS_SEL;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    rx_d    = '0;
                    sck_d   = MODE[MODE_CPOL];
                    state_d = ST_SETUP;
                    if (!MODE[MODE_CPHA]) begin
                        mosi_d = first_bit(DATA_MOSI);
                        tx_d   = tx_shift(DATA_MOSI);
                    end else begin
                        tx_d   = DATA_MOSI;
                    end
                end
            end
            ST_SETUP: begin
                // CS follows SCK by one cycle so the idle level is settled.
                csb_d = cs_decode(sel_q);
                if (tick) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (tick) begin
                    sck_d = ~sck_q;
                    if (lead) begin
                        if (!cpha) begin
                            rx_d  = rx_shift(rx_q, MISO);
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            mosi_d = first_bit(tx_q);
                            tx_d   = tx_shift(tx_q);
                        end
                    end else begin
                        if (cpha) begin
                            rx_d  = rx_shift(rx_q, MISO);
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            mosi_d = first_bit(tx_q);
                            tx_d   = tx_shift(tx_q);
                        end
                        if (cnt_d == BITS) state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                sck_d = mode_q[MODE_CPOL];
                if (tick) begin
                    state_d = ST_IDLE;
                    csb_d   = '1;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                    dm_d    = rx_q;
                end
            end
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RSTbar) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            sel_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            csb_q   <= '1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            dm_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            csb_q   <= csb_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            dm_q    <= dm_d;
        end
    end

    assign SCK       = sck_q;
    assign MOSI      = mosi_q;
    assign CSbar     = csb_q;
    assign BUSY      = busy_q;
    assign FIN       = fin_q;
    assign DATA_MISO = dm_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed scoreboard bench for three parameter
// sets of spi_master_param (default, 8-bit LSB-first x4 CS, 8-bit x3 CS).
module tb_spi_master_param;

    logic SYS_CLK = 1'b0;
    logic RSTbar  = 1'b0;
    logic [2:0] start = '0;
    logic [1:0] mode  = '0;
    logic [15:0] d0 = '0;
    logic [7:0]  d1 = '0;
    logic [7:0]  d2 = '0;
    logic [0:0]  cs0 = '0;
    logic [1:0]  cs1 = '0;
    logic [1:0]  cs2 = '0;

    logic sck0, sck1, sck2;
    logic mosi0, mosi1, mosi2;
    logic miso0;
    logic busy0, busy1, busy2;
    logic fin0, fin1, fin2;
    logic [0:0]  csb0;
    logic [3:0]  csb1;
    logic [2:0]  csb2;
    logic [15:0] dm0;
    logic [7:0]  dm1, dm2;

    int nvec = 0;
    int nmis = 0;
    logic [31:0] sb[$];

    logic        lb = 1'b1;
    logic [15:0] s_word = '0;
    logic        s_cpol = 1'b0;
    logic        s_cpha = 1'b0;
    int          s_k = 0;
    logic [15:0] cap = '0;

    logic        snap_sck, snap_mosi, cs_low;
    logic [31:0] snap_cs;

    always #5 SYS_CLK = ~SYS_CLK;

    spi_master_param #(
        .DATA_W(16), .CLK_DIV(4), .NUM_CS(1), .LSB_FIRST(0)
    ) u0 (
        .SYS_CLK(SYS_CLK), .RSTbar(RSTbar), .START(start[0]),
        .CS_SEL(cs0), .MODE(mode), .DATA_MOSI(d0), .MISO(miso0),
        .SCK(sck0), .MOSI(mosi0), .CSbar(csb0), .BUSY(busy0),
        .FIN(fin0), .DATA_MISO(dm0)
    );

    spi_master_param #(
        .DATA_W(8), .CLK_DIV(4), .NUM_CS(4), .LSB_FIRST(1)
    ) u1 (
        .SYS_CLK(SYS_CLK), .RSTbar(RSTbar), .START(start[1]),
        .CS_SEL(cs1), .MODE(mode), .DATA_MOSI(d1), .MISO(mosi1),
        .SCK(sck1), .MOSI(mosi1), .CSbar(csb1), .BUSY(busy1),
        .FIN(fin1), .DATA_MISO(dm1)
    );

    spi_master_param #(
        .DATA_W(8), .CLK_DIV(2), .NUM_CS(3), .LSB_FIRST(0)
    ) u2 (
        .SYS_CLK(SYS_CLK), .RSTbar(RSTbar), .START(start[2]),
        .CS_SEL(cs2), .MODE(mode), .DATA_MOSI(d2), .MISO(mosi2),
        .SCK(sck2), .MOSI(mosi2), .CSbar(csb2), .BUSY(busy2),
        .FIN(fin2), .DATA_MISO(dm2)
    );

    // Slave for u0: cpha=0 changes data on trailing edges, cpha=1 on leading.
    assign miso0 = lb ? mosi0
                 : ((s_k >= 0 && s_k < 16) ? s_word[15 - s_k] : 1'b0);

    always @(negedge csb0[0]) s_k = s_cpha ? -1 : 0;

    always @(sck0) begin
        if (!csb0[0]) begin
            if ((sck0 == s_cpol) != s_cpha) s_k = s_k + 1;
        end
    end

    always @(posedge sck0) cap = {cap[14:0], mosi0};

    function automatic logic fin_of(input int w);
        case (w)
            0: return fin0;
            1: return fin1;
            default: return fin2;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic sck_of(input int w);
        case (w)
            0: return sck0;
            1: return sck1;
            default: return sck2;
        endcase
    endfunction

    function automatic logic mosi_of(input int w);
        case (w)
            0: return mosi0;
            1: return mosi1;
            default: return mosi2;
        endcase
    endfunction

    function automatic logic [31:0] cs_of(input int w);
        case (w)
            0: return 32'(csb0);
            1: return 32'(csb1);
            default: return 32'(csb2);
        endcase
    endfunction

    function automatic logic cs_all_hi(input int w);
        case (w)
            0: return &csb0;
            1: return &csb1;
            default: return &csb2;
        endcase
    endfunction

    function automatic logic [31:0] dm_of(input int w);
        case (w)
            0: return 32'(dm0);
            1: return 32'(dm1);
            default: return 32'(dm2);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int w, input logic [31:0] exp, input int lat);
        int n;
        sb.push_back(exp);
        @(negedge SYS_CLK);
        start[w] = 1'b1;
        @(negedge SYS_CLK);
        start[w] = 1'b0;
        n = 0;
        cs_low = 1'b0;
        chk("busy_accept", 32'(busy_of(w)), 1);
        while (!fin_of(w) && n < lat + 50) begin
            if (n == 1) begin
                snap_sck  = sck_of(w);
                snap_mosi = mosi_of(w);
            end
            if (n == 2) snap_cs = cs_of(w);
            if (!cs_all_hi(w)) cs_low = 1'b1;
            @(negedge SYS_CLK);
            n++;
        end
        chk("fin_latency", n, lat);
        chk("data_miso", dm_of(w), sb.pop_front());
        @(negedge SYS_CLK);
        chk("fin_width", 32'(fin_of(w)), 0);
        chk("busy_end", 32'(busy_of(w)), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        int last;
        int k;

        // reset state
        repeat (3) @(negedge SYS_CLK);
        chk("rst_csb0", 32'(csb0), 32'h1);
        chk("rst_csb1", 32'(csb1), 32'hF);
        chk("rst_sck", 32'(sck0), 0);
        chk("rst_mosi", 32'(mosi0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_fin", 32'(fin0), 0);
        chk("rst_dm", 32'(dm0), 0);
        RSTbar = 1'b1;
        @(negedge SYS_CLK);

        // mode 0 loopback, MSB-first pattern and 136-cycle latency
        lb = 1'b1;
        mode = 2'd0;
        d0 = 16'hA5C3;
        cap = '0;
        xfer(0, 32'hA5C3, 136);
        chk("t1_mosi_pattern", 32'(cap), 32'hA5C3);
        chk("t1_first_mosi", 32'(snap_mosi), 1);
        chk("t1_setup_sck", 32'(snap_sck), 0);

        // all four modes against a shifting slave
        lb = 1'b0;
        s_word = 16'h3C0F;
        d0 = 16'h1234;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            s_cpol = mode[1];
            s_cpha = mode[0];
            xfer(0, 32'h3C0F, 136);
            chk("t2_setup_sck", 32'(snap_sck), 32'(mode[1]));
            chk("t2_idle_sck", 32'(sck0), 32'(mode[1]));
        end

        // START held high: back-to-back transfers, period 137
        lb = 1'b1;
        mode = 2'd0;
        d0 = 16'h5AA5;
        repeat (4) sb.push_back(32'h5AA5);
        nf = 0;
        last = -1;
        @(negedge SYS_CLK);
        start[0] = 1'b1;
        for (int n = 0; n <= 420; n++) begin
            @(negedge SYS_CLK);
            if (fin0) begin
                nf++;
                chk("b2b_cs_gap", 32'(csb0), 32'h1);
                chk("b2b_data", 32'(dm0), sb.pop_front());
                if (last >= 0) chk("b2b_period", n - last, 137);
                last = n;
            end
        end
        start[0] = 1'b0;
        chk("b2b_fin_count", nf, 3);
        k = 0;
        while (!fin0 && k < 200) begin
            @(negedge SYS_CLK);
            k++;
        end
        chk("b2b_last_fin", 32'(fin0), 1);
        chk("b2b_last_data", 32'(dm0), sb.pop_front());
        @(negedge SYS_CLK);

        // reset in XFER half-period 10 of a CPOL=1 transfer
        mode = 2'd2;
        d0 = 16'hF00D;
        @(negedge SYS_CLK);
        start[0] = 1'b1;
        @(negedge SYS_CLK);
        start[0] = 1'b0;
        repeat (44) @(negedge SYS_CLK);
        RSTbar = 1'b0;
        @(negedge SYS_CLK);
        chk("abort_csb", 32'(csb0), 32'h1);
        chk("abort_sck", 32'(sck0), 0);
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_dm", 32'(dm0), 0);
        chk("abort_mosi", 32'(mosi0), 0);
        RSTbar = 1'b1;
        nf = 0;
        for (int n = 0; n < 160; n++) begin
            if (fin0) nf++;
            @(negedge SYS_CLK);
        end
        chk("abort_no_fin", nf, 0);
        xfer(0, 32'hF00D, 136);

        // 8-bit LSB-first, 4 chip selects
        mode = 2'd0;
        cs1 = 2'd2;
        d1 = 8'h01;
        xfer(1, 32'h01, 72);
        chk("t3_first_mosi", 32'(snap_mosi), 1);
        chk("t3_cs", snap_cs, 32'hB);
        mode = 2'd1;
        cs1 = 2'd0;
        d1 = 8'hB4;
        xfer(1, 32'hB4, 72);
        chk("t3_cs0", snap_cs, 32'hE);

        // 3 chip selects: valid select, then out-of-range select
        mode = 2'd0;
        cs2 = 2'd1;
        d2 = 8'h96;
        xfer(2, 32'h96, 36);
        chk("t6_first_mosi", 32'(snap_mosi), 1);
        chk("t6_cs1", snap_cs, 32'h5);
        cs2 = 2'd3;
        d2 = 8'h3A;
        xfer(2, 32'h3A, 36);
        chk("t6_no_cs", 32'(cs_low), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
